uart_tx: RTL

Serial transmitter that sits directly upstream of the UART receiver: it accepts a parallel word with a single-cycle valid strobe and drives a start bit, LSB-first data, an optional parity bit and a stop bit onto the serial line. It runs on the same oversampled clock as the receiver and holds each bit for PRESCALE clocks. Its output connects straight to the receiver's RX_IN, in loopback or across a link.

---
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_tx.sv | 72 +++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-word request and serial-line status bundle for uart_tx.
// master drives P_DATA_TX, DATA_VALID_TX, PAR_EN, PAR_TYP and PRESCALE, and receives TX_OUT and Busy.
// slave is the transmitter side.
interface uart_tx_if #(parameter int width = 8);
  logic [width-1:0] P_DATA_TX;
  logic             DATA_VALID_TX;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [5:0]       PRESCALE;
  logic             TX_OUT;
  logic             Busy;
  modport master (output P_DATA_TX, DATA_VALID_TX, PAR_EN, PAR_TYP, PRESCALE, input TX_OUT, Busy);
  modport slave  (input P_DATA_TX, DATA_VALID_TX, PAR_EN, PAR_TYP, PRESCALE, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter (start bit, LSB-first data, optional parity, stop bit), PRESCALE clocks per bit.
// Ports: CLK_TX is the oversampled clock; RST_TX is an asynchronous active-low reset; bus is the request and line interface (slave side).
module uart_tx #(parameter int width = 8) (
  input logic     CLK_TX,
  input logic     RST_TX,
  uart_tx_if.slave bus
);
  localparam int iw = width > 1 ? $clog2(width) : 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0]       state;
  logic [5:0]       cnt, pre;
  logic [iw-1:0]    idx;
  logic [width-1:0] sh;
  logic             par_en, par_bit, tx_out, busy, last;
  // PRESCALE = 0 wraps pre - 1 to 63, giving 64 clocks per bit
  assign last = cnt == pre - 6'd1;
  assign bus.TX_OUT = tx_out;
  assign bus.Busy = busy;
  always_ff @(posedge CLK_TX or negedge RST_TX)
    if (!RST_TX) begin
      state <= IDLE;
      cnt <= '0;
      pre <= '0;
      idx <= '0;
      sh <= '0;
      par_en <= 1'b0;
      par_bit <= 1'b0;
      tx_out <= 1'b1;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.DATA_VALID_TX) begin
        state <= START;
        sh <= bus.P_DATA_TX;
        par_en <= bus.PAR_EN;
        par_bit <= bus.PAR_TYP ? ~^bus.P_DATA_TX : ^bus.P_DATA_TX;
        pre <= bus.PRESCALE;
        cnt <= '0;
        tx_out <= 1'b0;
        busy <= 1'b1;
      end
    end else if (!last) begin
      cnt <= cnt + 6'd1;
    end else begin
      cnt <= '0;
      case (state)
        START: begin
          state <= DATA;
          idx <= '0;
          tx_out <= sh[0];
        end
        DATA:
          if (idx == iw'(width - 1)) begin
            state <= par_en ? PARITY : STOP;
            tx_out <= par_en ? par_bit : 1'b1;
          end else begin
            // shift the word down so the next bit is always at position 1
            idx <= idx + 1'b1;
            sh <= sh >> 1;
            tx_out <= sh[1];
          end
        PARITY: begin
          state <= STOP;
          tx_out <= 1'b1;
        end
        default: begin
          state <= IDLE;
          tx_out <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
